mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory word port between two requesters: port 0 is the hardware page-table walker (read-only TLB refill fetches) and port 1 is the cache controller (line-fill reads, write-through writes).
- Sits between the MMU/cache subsystem and the external main_mem_* interface of the system top.
- Single-beat, one-outstanding transactions. Arbitration is round-robin.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT_CYCLES, 64, cycles to wait for mem_ready before abort. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- p0_addr  in  ADDR_W  PTW read address
- p0_read_req  in  1  PTW read request; level, held until p0_ready
- p0_rdata  out  DATA_W  PTW read data; valid while p0_ready=1
- p0_ready  out  1  one-cycle completion pulse to PTW
- p1_addr  in  ADDR_W  cache address
- p1_wdata  in  DATA_W  cache write data
- p1_read_req  in  1  cache read request; level
- p1_write_req  in  1  cache write request; level
- p1_rdata  out  DATA_W  cache read data; valid while p1_ready=1
- p1_ready  out  1  one-cycle completion pulse to cache
- mem_addr  out  ADDR_W  to main memory
- mem_data_out  out  DATA_W  write data to main memory
- mem_read_req  out  1  memory read request
- mem_write_req  out  1  memory write request
- mem_data_in  in  DATA_W  memory read data
- mem_ready  in  1  memory completion; single-cycle pulse
- grant_id  out  1  owner of the current transaction (0=PTW, 1=cache)
- busy  out  1  a transaction is in flight (state BUSY or DONE)
- timeout_err  out  1  abort pulse (see Optional Feature)

Behaviour:
- Reset and clocking:
  - Clock is clk. Reset is rst_n, synchronous, active-low.
  - On reset, all outputs are 0, state is IDLE, and the round-robin pointer last_grant=1, so PTW wins the first contention.
  - Reset mid-transaction drops the transaction silently; no ready pulse is issued.
- All outputs are registered.
- State IDLE:
  - p0 request = p0_read_req. p1 request = p1_read_req | p1_write_req.
  - If exactly one port requests, grant it.
  - If both request, grant the port != last_grant.
  - On grant:
    - Latch the address, plus write data and a write flag for p1. If p1_read_req and p1_write_req are both high, it is treated as a write.
    - Set grant_id and last_grant.
    - Go to BUSY.
  - No request: stay in IDLE.
- State BUSY:
  - mem_addr, mem_data_out, and mem_read_req or mem_write_req are driven from the latched values. They are asserted from the first cycle in BUSY, i.e. one cycle after the request is sampled.
  - Signals hold stable until mem_ready is sampled high.
  - On mem_ready: deassert mem_*_req on the next cycle, capture mem_data_in into the owner's rdata register, assert the owner's pX_ready, and go to DONE.
- State DONE:
  - pX_ready is high for exactly this one cycle.
  - Requests are ignored; the requester drops its request on the edge where it samples ready.
  - Next state is IDLE.
  - Minimum request-to-ready latency = memory latency + 2 cycles. Back-to-back grants have a 1-cycle IDLE gap.
- Writes: pX_ready also pulses on completion. p1_rdata captures mem_data_in, and its value is don't-care.
- mem_ready while in IDLE or DONE is ignored.
- Requests arriving during BUSY/DONE are held by the requester and arbitrated in the next IDLE cycle. No request is lost.
- The non-owner's ready and rdata are unaffected by a transaction; rdata holds its last value.
- busy = (state != IDLE).

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without mem_ready:
    - mem_*_req drops.
    - The owner's pX_ready pulses with pX_rdata=32'hDEAD_DEAD.
    - timeout_err pulses for the same cycle.
    - Next state is DONE → IDLE.
  - A mem_ready arriving after the abort is ignored.
- Not defined: BUSY waits indefinitely, and timeout_err is tied 0.

Test Plan:
- Sole PTW read at 0x000A_1000, memory latency 4, returns 0x000A_1000 → mem_read_req high for 4 cycles, p0_ready pulses once with p0_rdata=0x000A_1000, p1_ready stays 0, grant_id=0.
- Cache write of 0xDEAD_BEEF to 0x000A_1004 → mem_write_req=1, mem_addr=0x000A_1004, mem_data_out=0xDEAD_BEEF held until mem_ready; then p1_ready pulses and mem_write_req drops the next cycle.
- p0 and p1 read requests raised in the same cycle after reset → PTW served first; then after DONE+IDLE the cache is served. With both requests held continuously, grants alternate 0,1,0,1.
- Request during a busy transaction: p1 raises a request while p0 is in BUSY → p1 granted in the IDLE cycle after p0's DONE, with mem_addr=p1_addr.
- Reset mid-transaction: rst_n low for 1 cycle during BUSY → next cycle all outputs are 0 and no ready pulse occurs. A new p1 read then completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: memory never responds → after 8 BUSY cycles, timeout_err and p0_ready pulse together with p0_rdata=0xDEAD_DEAD; a later stray mem_ready is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the main-memory port served by mem_port_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] p0_addr;
   logic              p0_read_req;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_ready;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_read_req;
   logic              p1_write_req;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_read_req;
   logic              mem_write_req;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_ready;
   logic              grant_id;
   logic              busy;
   logic              timeout_err;

   modport master (
      input  p0_addr, p0_read_req, p1_addr, p1_wdata, p1_read_req, p1_write_req,
      input  mem_data_in, mem_ready,
      output p0_rdata, p0_ready, p1_rdata, p1_ready,
      output mem_addr, mem_data_out, mem_read_req, mem_write_req,
      output grant_id, busy, timeout_err
   );

   modport slave (
      output p0_addr, p0_read_req, p1_addr, p1_wdata, p1_read_req, p1_write_req,
      output mem_data_in, mem_ready,
      input  p0_rdata, p0_ready, p1_rdata, p1_ready,
      input  mem_addr, mem_data_out, mem_read_req, mem_write_req,
      input  grant_id, busy, timeout_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the main-memory word port between the PTW (port 0) and the cache (port 1).
// Optional BUSY-phase abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              grant_q, grant_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
   logic              p0_rdy_q, p0_rdy_d;
   logic              p1_rdy_q, p1_rdy_d;
   logic              busy_q;
   logic              req0, req1, pick;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 8-bit BUSY counter");
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       tout_q, tout_d;
`endif

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      p0_rdy_d   = 1'b0;
      p1_rdy_d   = 1'b0;
      req0       = bus.p0_read_req;
      req1       = bus.p1_read_req | bus.p1_write_req;
      // On contention the port that did not win last time is chosen.
      pick       = req1 & (~req0 | ~last_q);
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      tout_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               last_d  = pick;
               grant_d = pick;
               addr_d  = pick ? bus.p1_addr : bus.p0_addr;
               wdata_d = pick ? bus.p1_wdata : '0;
               wr_d    = pick & bus.p1_write_req;
               rd_d    = ~(pick & bus.p1_write_req);
               state_d = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         BUSY: begin
            if (bus.mem_ready) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = DONE;
               if (grant_q) begin
                  p1_rdata_d = bus.mem_data_in;
                  p1_rdy_d   = 1'b1;
               end else begin
                  p0_rdata_d = bus.mem_data_in;
                  p0_rdy_d   = 1'b1;
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               tout_d  = 1'b1;
               state_d = DONE;
               if (grant_q) begin
                  p1_rdata_d = DATA_W'(32'hDEAD_DEAD);
                  p1_rdy_d   = 1'b1;
               end else begin
                  p0_rdata_d = DATA_W'(32'hDEAD_DEAD);
                  p0_rdy_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         grant_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
         p0_rdy_q   <= 1'b0;
         p1_rdy_q   <= 1'b0;
         busy_q     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q      <= 8'd0;
         tout_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
         p0_rdy_q   <= p0_rdy_d;
         p1_rdy_q   <= p1_rdy_d;
         busy_q     <= (state_d != IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         tout_q     <= tout_d;
`endif
      end
   end

   assign bus.mem_addr      = addr_q;
   assign bus.mem_data_out  = wdata_q;
   assign bus.mem_read_req  = rd_q;
   assign bus.mem_write_req = wr_q;
   assign bus.p0_rdata      = p0_rdata_q;
   assign bus.p0_ready      = p0_rdy_q;
   assign bus.p1_rdata      = p1_rdata_q;
   assign bus.p1_ready      = p1_rdy_q;
   assign bus.grant_id      = grant_q;
   assign bus.busy          = busy_q;
`ifdef MEM_ARB_TIMEOUT_EN
   assign bus.timeout_err   = tout_q;
`else
   assign bus.timeout_err   = 1'b0;
`endif

endmodule
